als_avg_filter: RTL and testbench



---
 rtl/als_avg_filter_pkg.sv | 15 +
 rtl/als_ring_buf.sv | 36 +++
 rtl/als_avg_filter.sv | 123 ++++++++++++
 tb/tb_als_avg_filter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/als_avg_filter_pkg.sv
// rtl/als_avg_filter_pkg.sv - shared constants and FSM encoding for the ALS averaging filter
package als_avg_filter_pkg;

  localparam int ALS_DATA_W  = 8;
  localparam int LOW_TH_DEF  = 50;
  localparam int HIGH_TH_DEF = 70;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_OUT    = 2'd3
  } als_state_e;

endpackage

// File: rtl/als_ring_buf.sv
// rtl/als_ring_buf.sv - DEPTH x 8 sample ring with synchronous read of the oldest entry
module als_ring_buf
  import als_avg_filter_pkg::*;
#(
  parameter int LOG2_N = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  output logic [ALS_DATA_W-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ALS_DATA_W-1:0] wr_data
);

  localparam int DEPTH = 1 << LOG2_N;

  logic [ALS_DATA_W-1:0] mem [DEPTH];
  logic [LOG2_N-1:0]     wptr;

  // The write pointer always addresses the oldest entry, so reads and writes share it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr    <= '0;
      rd_data <= '0;
    end else begin
      if (rd_en) rd_data <= mem[wptr];
      if (wr_en) begin
        mem[wptr] <= wr_data;
        if (wptr == LOG2_N'(DEPTH - 1)) wptr <= '0;
        else                            wptr <= wptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/als_avg_filter.sv
// rtl/als_avg_filter.sv - PmodALS sample capture, moving average and hysteresis dark flag
module als_avg_filter
  import als_avg_filter_pkg::*;
#(
  parameter int LOG2_N  = 2,
  parameter int LOW_TH  = LOW_TH_DEF,
  parameter int HIGH_TH = HIGH_TH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ALS_DATA_W-1:0] data,
  input  logic                  read_flag,
  output logic [ALS_DATA_W-1:0] avg,
  output logic                  avg_valid,
  output logic                  dark,
  output logic                  filled,
  output logic                  overrun
);

  localparam int SUM_W = ALS_DATA_W + LOG2_N;
  localparam int DEPTH = 1 << LOG2_N;
  localparam logic [LOG2_N:0]       DEPTH_CNT = (LOG2_N + 1)'(DEPTH);
  localparam logic [ALS_DATA_W-1:0] LOW_Q     = ALS_DATA_W'(LOW_TH);
  localparam logic [ALS_DATA_W-1:0] HIGH_Q    = ALS_DATA_W'(HIGH_TH);

  als_state_e state, state_nxt;

  logic                  s1, s2, d;
  logic                  sample_edge;
  logic [ALS_DATA_W-1:0] sample_q;
  logic [ALS_DATA_W-1:0] oldest;
  logic [SUM_W-1:0]      sum, sum_nxt;
  logic [ALS_DATA_W-1:0] avg_nxt;
  logic [LOG2_N:0]       fill_cnt, fill_nxt;
  logic                  do_capture, do_read, do_update;

  // Flops reset high so a read_flag already idle at reset release is not seen as a rise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      d  <= 1'b1;
    end else begin
      s1 <= read_flag;
      s2 <= s1;
      d  <= s2;
    end
  end

  assign sample_edge = s2 & ~d;

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    do_capture = 1'b0;
    do_read    = 1'b0;
    do_update  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sample_edge) begin
          do_capture = 1'b1;
          state_nxt  = ST_READ;
        end
      end
      ST_READ: begin
        do_read   = 1'b1;
        state_nxt = ST_UPDATE;
      end
      ST_UPDATE: begin
        do_update = 1'b1;
        state_nxt = ST_OUT;
      end
      ST_OUT:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  als_ring_buf #(.LOG2_N(LOG2_N)) u_ring (
    .clk     (clk),
    .reset   (reset),
    .rd_en   (do_read),
    .rd_data (oldest),
    .wr_en   (do_update),
    .wr_data (sample_q)
  );

  // Sum is wide enough for DEPTH full-scale samples, so wrap-around never occurs.
  assign sum_nxt  = sum + SUM_W'(sample_q) - SUM_W'(oldest);
  assign avg_nxt  = ALS_DATA_W'(sum_nxt >> LOG2_N);
  assign fill_nxt = (fill_cnt == DEPTH_CNT) ? fill_cnt : fill_cnt + 1'b1;

  // avg, dark and filled are registered on entry to OUT so they line up with the strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sample_q  <= '0;
      sum       <= '0;
      fill_cnt  <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
      dark      <= 1'b0;
      filled    <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (do_capture) sample_q <= data;
      if (sample_edge && state != ST_IDLE) overrun <= 1'b1;
      if (do_update) begin
        sum       <= sum_nxt;
        fill_cnt  <= fill_nxt;
        avg       <= avg_nxt;
        avg_valid <= 1'b1;
        if (fill_nxt == DEPTH_CNT) filled <= 1'b1;
        if (avg_nxt < LOW_Q)       dark   <= 1'b1;
        else if (avg_nxt > HIGH_Q) dark   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_als_avg_filter.sv
// tb/tb_als_avg_filter.sv - directed self-checking bench for als_avg_filter
module tb_als_avg_filter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       read_flag;
  logic [7:0] avg;
  logic       avg_valid;
  logic       dark;
  logic       filled;
  logic       overrun;

  int n_tests = 0;
  int n_fail  = 0;

  als_avg_filter #(.LOG2_N(2), .LOW_TH(50), .HIGH_TH(70)) dut (
    .clk       (clk),
    .reset     (reset),
    .data      (data),
    .read_flag (read_flag),
    .avg       (avg),
    .avg_valid (avg_valid),
    .dark      (dark),
    .filled    (filled),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Counts posedges from the pin rise to the strobe; bounded so a missing strobe still ends.
  task automatic send(input string tag, input logic [7:0] v, input int exp_avg,
                      input int exp_dark, input int exp_filled);
    int lat;
    @(negedge clk);
    data      = v;
    read_flag = 1'b0;
    repeat (10) @(negedge clk);
    read_flag = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (avg_valid) lat = i;
    end
    check({tag, "_lat"},    lat,    5);
    check({tag, "_avg"},    avg,    exp_avg);
    check({tag, "_dark"},   dark,   exp_dark);
    check({tag, "_filled"}, filled, exp_filled);
    @(posedge clk); #1;
    check({tag, "_pulse"}, avg_valid, 0);
  endtask

  task automatic count_strobes(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (avg_valid) n++;
    end
  endtask

  initial begin
    int n;
    reset     = 1'b0;
    read_flag = 1'b1;
    data      = 8'd0;

    count_strobes(20, n);
    check("rst_strobes", n, 0);
    check("rst_avg", avg, 0);
    check("rst_dark", dark, 0);
    check("rst_filled", filled, 0);
    check("rst_overrun", overrun, 0);
    @(negedge clk);
    reset = 1'b1;
    count_strobes(10, n);
    check("post_rst_strobes", n, 0);

    send("s40",  8'd40,  10,  1, 0);
    send("s80",  8'd80,  30,  1, 0);
    send("s120", 8'd120, 60,  1, 0);
    send("s160", 8'd160, 100, 0, 1);
    send("s200", 8'd200, 140, 0, 1);
    // Zeros evict 80,120,160,200 in turn; avg exactly 50 must hold dark low.
    send("z1", 8'd0, 120, 0, 1);
    send("z2", 8'd0, 90,  0, 1);
    send("z3", 8'd0, 50,  0, 1);
    send("z4", 8'd0, 0,   1, 1);
    check("no_overrun_yet", overrun, 0);

    // Two rises two cycles apart: the second lands while busy and is dropped.
    @(negedge clk);
    data      = 8'd100;
    read_flag = 1'b0;
    @(negedge clk) read_flag = 1'b1;
    @(negedge clk) read_flag = 1'b0;
    @(negedge clk) read_flag = 1'b1;
    count_strobes(20, n);
    check("ovr_strobes", n, 1);
    check("ovr_avg", avg, 25);
    check("ovr_flag", overrun, 1);
    check("ovr_dark", dark, 1);

    // Reset lands on the edge that would leave UPDATE.
    @(negedge clk);
    data      = 8'd64;
    read_flag = 1'b0;
    repeat (10) @(negedge clk);
    read_flag = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("midrst_valid", avg_valid, 0);
    check("midrst_avg", avg, 0);
    check("midrst_filled", filled, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_dark", dark, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    count_strobes(10, n);
    check("midrst_strobes", n, 0);

    send("s64", 8'd64, 16, 1, 0);
    check("final_overrun", overrun, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
